nubus_mem_master: RTL and testbench
===================================

// Module: nubus_mem_master
// PURPOSE
//  Initiator for the card-local mem_valid/mem_ready memory bus (the bus our memory responders serve).
//  Accepts one request at a time on a valid/ready command port, drives a single bus transaction,
//  and returns read data or write completion on a valid/ready response port.
//  Sits between the NuBus slave decode/CPU side and the on-card memory responders.
//  A watchdog aborts transactions the responder never acknowledges.
// PARAMETERS
//  TIMEOUT_CLKS  16  max clocks mem_valid stays high without mem_ready before abort (>=2)
//  TIMEOUT_W     5   counter width, must hold TIMEOUT_CLKS
// PORTS
//  mem_clk     in   1   clock, all logic on rising edge
//  mem_resetn  in   1   asynchronous, active-low reset
//  cmd_valid   in   1   request present
//  cmd_ready   out  1   request accepted when cmd_valid & cmd_ready at posedge
//  cmd_write   in   4   byte write strobes; 0000 = read
//  cmd_addr    in   32  byte address
//  cmd_wdata   in   32  write data
//  rsp_valid   out  1   response present, held until rsp_ready
//  rsp_ready   in   1   response consumed when rsp_valid & rsp_ready at posedge
//  rsp_rdata   out  32  read data; bytes whose strobe was set read as 0
//  rsp_write   out  1   response belongs to a write (cmd_write != 0)
//  rsp_error   out  1   transaction aborted by watchdog
//  mem_valid   out  1   bus request
//  mem_write   out  4   bus byte strobes
//  mem_addr    out  32  bus address, bits [1:0] always 0
//  mem_wdata   out  32  bus write data
//  mem_rdata   in   32  bus read data (bytes may be Z where strobe set)
//  mem_ready   in   1   bus acknowledge, combinational from responder
// BEHAVIOUR
//  Reset (async, mem_resetn=0): state IDLE; mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0,
//   rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_error=0, watchdog=0; cmd_ready=1 after release.
//   Reset mid-transaction drops mem_valid immediately; pending command/response are discarded.
//  States: IDLE -> BUS -> RESP -> IDLE.
//  IDLE: cmd_ready=1. On accept: register cmd_write/cmd_addr ({addr[31:2],2'b00})/cmd_wdata onto
//   mem_*, mem_valid=1 from next cycle, watchdog=0, go BUS.
//  BUS: cmd_ready=0; mem_valid, mem_write, mem_addr, mem_wdata held stable.
//   posedge with mem_ready=1: capture rsp_rdata byte i = mem_write[i] ? 8'h00 : mem_rdata byte i;
//   rsp_write=|mem_write, rsp_error=0, mem_valid=0, mem_write=0, rsp_valid=1, go RESP.
//   else watchdog++; at watchdog==TIMEOUT_CLKS-1 without ready: mem_valid=0, rsp_rdata=0,
//   rsp_error=1, rsp_valid=1, go RESP. mem_ready and timeout on same edge: ready wins, no error.
//  RESP: mem_valid=0 (guarantees >=1 idle bus cycle between transactions so responder wait
//   pipelines clear); cmd_ready=0; rsp_* stable; on rsp_ready go IDLE, rsp_valid=0.
//  Latency: accept edge k -> mem_valid high from k; responder with wait 0/1 acks at k+1, wait W>=2
//   at k+W; rsp_valid rises the edge ready is sampled. Min command-to-command spacing 3 clocks.
//  mem_ready while mem_valid=0 is ignored. Misaligned cmd_addr bits [1:0] are dropped silently.
//  Watchdog saturates; never wraps.
// STRUCTURE
//  nubus_mem_pkg: state enum (IDLE/BUS/RESP), default TIMEOUT_CLKS, byte-mask function.
//  One sub-module: nubus_mem_watchdog (clear/enable/expire counter, TIMEOUT_CLKS parameter).
//  Remainder (FSM, bus registers, response register) in this module.
// TESTING
//  Bench pairs this block with a memory responder (wait_clocks selectable) and scoreboard.
//  1 write 0x1234_5678, strobes 1111, addr 0x10, wait 0 -> mem_valid 1 clk, rsp_valid, rsp_write=1, err 0.
//  2 read addr 0x10, wait 3 -> mem_valid exactly 3 clks, rsp_rdata=0x1234_5678, rsp_error=0.
//  3 write 0xAABB_CCDD strobes 0100 then read addr 0x12 -> read returns 0x12BB_5678 (addr bits[1:0] dropped).
//  4 responder ready tied 0 -> mem_valid high 16 clks, then rsp_valid, rsp_error=1, rsp_rdata=0.
//  5 rsp_ready held 0 for 5 clks, cmd_valid held 1 -> no second mem_valid until response taken,
//    then >=1 idle bus cycle before next mem_valid.
//  6 assert mem_resetn=0 mid-BUS with wait 3 -> mem_valid falls same cycle, rsp_valid stays 0,
//    cmd_ready=1 first clock after release.

Source files
------------

// File: rtl/nubus_mem_pkg.sv
// Shared types and helpers for the card-local memory bus initiator.
package nubus_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  localparam int unsigned TimeoutClksDefault = 16;
  localparam int unsigned TimeoutWDefault    = 5;

  // Expand 4 byte strobes into a 32-bit byte mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/nubus_mem_master_if.sv
// Command, response and memory-bus signals of the initiator, grouped by direction.
interface nubus_mem_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_error;
  logic        mem_valid;
  logic [3:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_rdata, mem_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error,
    output mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_rdata, mem_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error,
    input  mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nubus_mem_watchdog.sv
// Saturating clock counter that flags when a bus request has waited too long.
module nubus_mem_watchdog #(
  parameter int unsigned TIMEOUT_CLKS = 16,
  parameter int unsigned TIMEOUT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] Limit = TIMEOUT_W'(TIMEOUT_CLKS - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Limit)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == Limit);

endmodule

// File: rtl/nubus_mem_master.sv
// Single-outstanding initiator for the mem_valid/mem_ready bus with a timeout watchdog.
module nubus_mem_master
  import nubus_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = TimeoutClksDefault,
  parameter int unsigned TIMEOUT_W    = TimeoutWDefault
) (
  input logic               mem_clk,
  input logic               mem_resetn,
  nubus_mem_master_if.master bus
);

  state_e      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [3:0]  mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_error_q, rsp_error_d;

  logic accept, ack, expire, abort, taken;

  assign accept = (state_q == StIdle) && bus.cmd_valid;
  assign ack    = (state_q == StBus) && bus.mem_ready;
  // Ready on the expiry edge still completes normally.
  assign abort  = (state_q == StBus) && !bus.mem_ready && expire;
  assign taken  = (state_q == StResp) && bus.rsp_ready;

  nubus_mem_watchdog #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_watchdog (
    .clk   (mem_clk),
    .rst_n (mem_resetn),
    .clear (accept),
    .enable((state_q == StBus) && !bus.mem_ready),
    .expire(expire)
  );

  always_ff @(posedge mem_clk or negedge mem_resetn) begin
    if (!mem_resetn) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      mem_write_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBus;
      StBus:   if (ack || abort) state_d = StResp;
      StResp:  if (taken) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    if (accept) begin
      mem_valid_d = 1'b1;
      mem_write_d = bus.cmd_write;
      mem_addr_d  = {bus.cmd_addr[31:2], 2'b00};
      mem_wdata_d = bus.cmd_wdata;
    end
    if (ack) begin
      // Strobed bytes may float on the bus, so force them to zero.
      rsp_rdata_d = bus.mem_rdata & ~byte_mask(mem_write_q);
      rsp_write_d = |mem_write_q;
      rsp_error_d = 1'b0;
      rsp_valid_d = 1'b1;
      mem_valid_d = 1'b0;
      mem_write_d = '0;
    end
    if (abort) begin
      rsp_rdata_d = '0;
      rsp_write_d = |mem_write_q;
      rsp_error_d = 1'b1;
      rsp_valid_d = 1'b1;
      mem_valid_d = 1'b0;
      mem_write_d = '0;
    end
    if (taken) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_nubus_mem_master.sv
// Directed bench: initiator paired with a wait-state memory responder.
module tb_nubus_mem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nubus_mem_master_if bus ();

  nubus_mem_master #(
    .TIMEOUT_CLKS(16),
    .TIMEOUT_W   (5)
  ) dut (
    .mem_clk   (clk),
    .mem_resetn(rst_n),
    .bus       (bus)
  );

  // Responder: acks after wait_clks (0/1 -> next edge), or never while stall is set.
  logic [31:0] mem [0:63];
  int          wait_clks = 0;
  logic        stall = 1'b0;
  int          cyc = 0;
  int          need;

  assign need          = (wait_clks < 2) ? 0 : wait_clks - 1;
  assign bus.mem_ready = bus.mem_valid && !stall && (cyc >= need);
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always_ff @(posedge clk) begin
    if (!bus.mem_valid || bus.mem_ready) cyc <= 0;
    else cyc <= cyc + 1;
    if (bus.mem_valid && bus.mem_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_write[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, count mem_valid clocks, then consume the response.
  task automatic do_cmd(input logic [3:0] wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int vcyc, output logic [31:0] rd, output logic rw,
                        output logic re, output logic [31:0] baddr);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    tick();
    bus.cmd_valid = 1'b0;
    baddr = bus.mem_addr;
    vcyc  = 0;
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
      if (bus.mem_valid) vcyc++;
      tick();
    end
    checks++;
    if (!bus.rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1", bus.rsp_valid);
    end
    rd = bus.rsp_rdata;
    rw = bus.rsp_write;
    re = bus.rsp_error;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    got = {bus.mem_valid, bus.mem_write, bus.rsp_valid, bus.rsp_write, bus.rsp_error,
           bus.cmd_ready, 24'h0};
    checks++;
    if (got !== {8'b0000_0001, 24'h0}) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required %h", got, {8'b0000_0001, 24'h0});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {bus.mem_addr, bus.mem_wdata, bus.rsp_rdata});
    end
  endtask

  task automatic test_write_wait0();
    int v; logic [31:0] rd, ba; logic rw, re;
    wait_clks = 0;
    do_cmd(4'b1111, 32'h10, 32'h1234_5678, v, rd, rw, re, ba);
    checks++;
    if (v !== 1) begin errors++; $display("FAIL wr_valid_clks: got %0d required 1", v); end
    checks++;
    if ({rw, re} !== 2'b10) begin errors++; $display("FAIL wr_flags: got %b required 10", {rw, re}); end
    checks++;
    if (ba !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h required 00000010", ba); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h required 0", rd); end
  endtask

  task automatic test_read_wait3();
    int v; logic [31:0] rd, ba; logic rw, re;
    wait_clks = 3;
    do_cmd(4'b0000, 32'h10, 32'h0, v, rd, rw, re, ba);
    checks++;
    if (v !== 3) begin errors++; $display("FAIL rd_valid_clks: got %0d required 3", v); end
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h required 12345678", rd); end
    checks++;
    if ({rw, re} !== 2'b00) begin errors++; $display("FAIL rd_flags: got %b required 00", {rw, re}); end
  endtask

  task automatic test_strobe_misaligned();
    int v; logic [31:0] rd, ba; logic rw, re;
    wait_clks = 0;
    do_cmd(4'b0100, 32'h10, 32'hAABB_CCDD, v, rd, rw, re, ba);
    checks++;
    if (rd !== 32'h1200_5678) begin errors++; $display("FAIL strb_rdata: got %h required 12005678", rd); end
    wait_clks = 1;
    do_cmd(4'b0000, 32'h12, 32'h0, v, rd, rw, re, ba);
    checks++;
    if (ba !== 32'h10) begin errors++; $display("FAIL misalign_addr: got %h required 00000010", ba); end
    checks++;
    if (rd !== 32'h12BB_5678) begin errors++; $display("FAIL misalign_rd: got %h required 12bb5678", rd); end
    checks++;
    if (v !== 1) begin errors++; $display("FAIL wait1_clks: got %0d required 1", v); end
  endtask

  task automatic test_timeout();
    int v; logic [31:0] rd, ba; logic rw, re;
    stall = 1'b1;
    do_cmd(4'b0000, 32'h20, 32'h0, v, rd, rw, re, ba);
    stall = 1'b0;
    checks++;
    if (v !== 16) begin errors++; $display("FAIL to_valid_clks: got %0d required 16", v); end
    checks++;
    if ({re, rd} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL to_rsp: got err=%b data=%h required err=1 data=0", re, rd);
    end
    checks++;
    if ({bus.mem_valid, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL to_idle: got %b required 01", {bus.mem_valid, bus.cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    int i;
    wait_clks = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 4'b0000;
    bus.cmd_addr  = 32'h10;
    bus.cmd_wdata = 32'h0;
    for (i = 0; i < 10 && !bus.rsp_valid; i++) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.mem_valid || bus.cmd_ready) extra++;
    end
    checks++;
    if (extra !== 0 || !bus.rsp_valid) begin
      errors++; $display("FAIL b2b_hold: got extra=%0d rsp_valid=%b required 0/1", extra, bus.rsp_valid);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.mem_valid, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_gap: got %b required 001", {bus.mem_valid, bus.rsp_valid, bus.cmd_ready});
    end
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL b2b_next: got %b required 1", bus.mem_valid); end
    for (i = 0; i < 10 && !bus.rsp_valid; i++) tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    wait_clks = 3;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 4'b0000;
    bus.cmd_addr  = 32'h10;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    checks++;
    if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b required 1", bus.mem_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_valid, bus.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_async: got %b required 00", {bus.mem_valid, bus.rsp_valid});
    end
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_ready, bus.mem_valid, bus.rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rst_release: got %b required 100", {bus.cmd_ready, bus.mem_valid, bus.rsp_valid});
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 4'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_write_wait0();
    test_read_wait3();
    test_strobe_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
